apb_master_ctl: RTL and testbench

//  Parametrised APB4 master: turns a valid/ready command stream into APB SETUP/ACCESS transfers
//  to one of NSLV slaves, and returns read data and error status on a valid/ready response stream.

---
 rtl/apb_master_ctl_pkg.sv | 14 +
 rtl/apb_master_ctl_if.sv | 44 ++++
 rtl/apb_master_ctl_wait_timer.sv | 21 ++
 rtl/apb_master_ctl.sv | 135 +++++++++++++
 tb/tb_apb_master_ctl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_ctl_pkg.sv
// Shared types for the APB master: FSM states, response causes, default widths
// and the slave-index width helper.
package apb_master_ctl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;
  typedef enum logic [1:0] {CAUSE_OK, CAUSE_SLVERR, CAUSE_DECODE, CAUSE_TIMEOUT} cause_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NSLV   = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/apb_master_ctl_if.sv
// Command, response and APB bus bundle; master = the controller, slave = fabric + peripherals.
interface apb_master_ctl_if
  import apb_master_ctl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NSLV   = DEF_NSLV
);
  localparam int STRB_W = DATA_W / 8;

  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic                   i_cmd_write;
  logic [ADDR_W-1:0]      i_cmd_addr;
  logic [DATA_W-1:0]      i_cmd_wdata;
  logic [STRB_W-1:0]      i_cmd_strb;
  logic                   o_rsp_valid;
  logic                   i_rsp_ready;
  logic [DATA_W-1:0]      o_rsp_rdata;
  logic                   o_rsp_err;
  logic                   o_rsp_timeout;
  logic [ADDR_W-1:0]      o_paddr;
  logic [NSLV-1:0]        o_psel;
  logic                   o_penable;
  logic                   o_pwrite;
  logic [DATA_W-1:0]      o_pwdata;
  logic [STRB_W-1:0]      o_pstrb;
  logic [NSLV-1:0]        i_pready;
  logic [NSLV*DATA_W-1:0] i_prdata;
  logic [NSLV-1:0]        i_pslverr;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_strb, i_rsp_ready,
           i_pready, i_prdata, i_pslverr,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
           o_paddr, o_psel, o_penable, o_pwrite, o_pwdata, o_pstrb
  );
  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_strb, i_rsp_ready,
           i_pready, i_prdata, i_pslverr,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
           o_paddr, o_psel, o_penable, o_pwrite, o_pwdata, o_pstrb
  );
endinterface

// File: rtl/apb_master_ctl_wait_timer.sv
// Counts stalled ACCESS cycles; o_done flags the cycle that would be the LIMIT-th stall.
module apb_master_ctl_wait_timer #(
  parameter int LIMIT = 16
)(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_done
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) r_cnt <= '0;
    else if (i_en)          r_cnt <= r_cnt + 1'b1;
  end

  assign o_done = i_en && (r_cnt == W'(LIMIT - 1));
endmodule

// File: rtl/apb_master_ctl.sv
// APB4 master: one command in flight, SETUP/ACCESS sequencing, PSEL decode,
// per-slave input mux, decode errors and wait-state timeout.
module apb_master_ctl
  import apb_master_ctl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NSLV        = DEF_NSLV,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT_CYC = 16
)(
  input logic              i_clk,
  input logic              i_reset,
  apb_master_ctl_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idx_w(NSLV);

  state_t            r_state, w_next;
  cause_t            r_cause;
  logic              r_started;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [STRB_W-1:0] r_strb;
  logic [IDX_W-1:0]  r_idx;

  logic [IDX_W-1:0]  w_idx;
  logic              w_dec, w_acc, w_pready, w_pslverr, w_tmo;
  logic [DATA_W-1:0] w_prdata;
  logic [NSLV-1:0]   w_onehot;
  logic [DATA_W-1:0] w_rd_arr [NSLV];

  assign w_idx = (NSLV == 1) ? '0 : bus.i_cmd_addr[SEL_LSB +: IDX_W];
  assign w_dec = {1'b0, w_idx} >= (IDX_W + 1)'(NSLV);
  assign w_acc = bus.i_cmd_valid && bus.o_cmd_ready;

  // Only the addressed slave's handshake and data are ever looked at.
  for (genvar k = 0; k < NSLV; k++) begin : g_rd
    assign w_rd_arr[k] = bus.i_prdata[k*DATA_W +: DATA_W];
  end
  assign w_prdata  = w_rd_arr[r_idx];
  assign w_pready  = bus.i_pready[r_idx];
  assign w_pslverr = bus.i_pslverr[r_idx];
  assign w_onehot  = NSLV'(1) << r_idx;

  if (TIMEOUT_CYC > 0) begin : g_tmr
    apb_master_ctl_wait_timer #(.LIMIT(TIMEOUT_CYC)) u_tmr (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (r_state != ST_ACCESS),
      .i_en    (r_state == ST_ACCESS && !w_pready),
      .o_done  (w_tmo)
    );
  end else begin : g_no_tmr
    assign w_tmo = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_acc) w_next = w_dec ? ST_RESP : ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (w_pready || w_tmo) w_next = ST_RESP;
      ST_RESP:   if (bus.i_rsp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.o_cmd_ready = 1'b0;
    bus.o_rsp_valid = 1'b0;
    bus.o_psel      = '0;
    bus.o_penable   = 1'b0;
    case (r_state)
      ST_IDLE:   bus.o_cmd_ready = r_started;
      ST_SETUP:  bus.o_psel = w_onehot;
      ST_ACCESS: begin
        bus.o_psel    = w_onehot;
        bus.o_penable = 1'b1;
      end
      ST_RESP:   bus.o_rsp_valid = 1'b1;
      default:   ;
    endcase
  end

  // APB address/data registers only move on a decodable command, so the bus
  // keeps showing the last real transfer while idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_started <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_idx     <= '0;
      r_rdata   <= '0;
      r_cause   <= CAUSE_OK;
    end else begin
      r_started <= 1'b1;
      if (w_acc) begin
        r_rdata <= '0;
        r_cause <= w_dec ? CAUSE_DECODE : CAUSE_OK;
        if (!w_dec) begin
          r_write <= bus.i_cmd_write;
          r_addr  <= bus.i_cmd_addr;
          r_wdata <= bus.i_cmd_wdata;
          r_strb  <= bus.i_cmd_write ? bus.i_cmd_strb : '0;
          r_idx   <= w_idx;
        end
      end
      if (r_state == ST_ACCESS) begin
        if (w_pready) begin
          r_rdata <= (!r_write && !w_pslverr) ? w_prdata : '0;
          r_cause <= w_pslverr ? CAUSE_SLVERR : CAUSE_OK;
        end else if (w_tmo) begin
          r_cause <= CAUSE_TIMEOUT;
        end
      end
    end
  end

  assign bus.o_paddr       = r_addr;
  assign bus.o_pwrite      = r_write;
  assign bus.o_pwdata      = r_wdata;
  assign bus.o_pstrb       = r_strb;
  assign bus.o_rsp_rdata   = r_rdata;
  assign bus.o_rsp_err     = (r_cause != CAUSE_OK);
  assign bus.o_rsp_timeout = (r_cause == CAUSE_TIMEOUT);
endmodule

// File: tb/tb_apb_master_ctl.sv
// Randomized bench for apb_master_ctl: command driver, scripted APB slave model
// and a scoreboard monitor on the response stream.
module tb_apb_master_ctl;
  localparam int AW = 32, DW = 32, NS = 3, SL = 12, TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0, n_chk = 0, n_pass = 0;
  bit   bp = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_master_ctl_if #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NS)) bus();

  apb_master_ctl #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NS), .SEL_LSB(SL), .TIMEOUT_CYC(TO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [2:0] psel; logic wr; logic [31:0] addr, wdata, data; logic [3:0] strb;
    int wt; logic serr;
  } plan_t;
  typedef struct { logic [31:0] rdata; logic err, tmo, dec; int nacc; int due; } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", nm, act, exp, cyc);
  endtask

  task automatic bound_fail(input string nm);
    n_chk++;
    $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
  endtask

  // Reference model: expected outcome follows from the address, the slave's
  // scripted wait count and its error flag.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int wt, input logic serr,
                      input logic [31:0] data);
    int t, idx; plan_t p; exp_t e;
    bus.i_cmd_valid = 1'b1; bus.i_cmd_write = wr; bus.i_cmd_addr = addr;
    bus.i_cmd_wdata = wdata; bus.i_cmd_strb = strb;
    t = 0;
    while (!bus.o_cmd_ready && t < 300) begin @(negedge clk); t++; end
    if (!bus.o_cmd_ready) begin bound_fail("cmd_accept"); bus.i_cmd_valid = 1'b0; return; end
    idx    = int'((addr >> SL) % 4);
    e.dec  = (idx >= NS);
    e.tmo  = !e.dec && (wt >= TO);
    e.nacc = e.dec ? 0 : (wt >= TO ? TO : wt + 1);
    e.err  = e.dec || e.tmo || serr;
    e.rdata = (!wr && !e.err) ? data : 32'h0;
    e.due  = cyc + (e.dec ? 1 : 2 + e.nacc);
    if (!e.dec) begin
      p.psel = 3'(1 << idx); p.wr = wr; p.addr = addr; p.wdata = wdata; p.data = data;
      p.strb = wr ? strb : 4'h0; p.wt = wt; p.serr = serr;
      plan_q.push_back(p);
    end
    exp_q.push_back(e);
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_addr  = $urandom; bus.i_cmd_wdata = $urandom;
    bus.i_cmd_strb  = 4'($urandom); bus.i_cmd_write = 1'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) bound_fail("drain");
  endtask

  // APB slave model: unselected slaves drive noise every cycle.
  plan_t       cur;
  bit          have_cur = 1'b0;
  int          nacc_seen = 0;
  logic [31:0] last_addr = '0;
  logic [3:0]  last_strb = '0;

  always @(negedge clk) begin : slv
    int k;
    for (int s = 0; s < NS; s++) begin
      bus.i_pready[s]  = 1'($urandom);
      bus.i_pslverr[s] = 1'($urandom);
      bus.i_prdata[s*32 +: 32] = $urandom;
    end
    if (rst) begin
      have_cur = 1'b0; last_addr = '0; last_strb = '0;
    end else if (bus.o_psel == '0) begin
      chk("idle_hold", {bus.o_penable, bus.o_paddr, bus.o_pstrb}, {1'b0, last_addr, last_strb});
    end else begin
      k = 0;
      for (int s = 0; s < NS; s++) if (bus.o_psel[s]) k = s;
      if (!bus.o_penable) begin
        if (plan_q.size() == 0) begin
          n_chk++; have_cur = 1'b0;
          $display("FAIL setup_unexpected: psel=%b with no transfer pending at cycle %0d", bus.o_psel, cyc);
        end else begin
          cur = plan_q.pop_front(); have_cur = 1'b1; nacc_seen = 0;
          chk("setup_psel", bus.o_psel, cur.psel);
          chk("setup_paddr", bus.o_paddr, cur.addr);
          chk("setup_pwrite_pstrb", {bus.o_pwrite, bus.o_pstrb}, {cur.wr, cur.strb});
          if (cur.wr) chk("setup_pwdata", bus.o_pwdata, cur.wdata);
          last_addr = cur.addr; last_strb = cur.strb;
        end
      end else if (have_cur) begin
        nacc_seen++;
        chk("access_hold", {bus.o_psel, bus.o_pwrite, bus.o_pstrb, bus.o_paddr},
            {cur.psel, cur.wr, cur.strb, cur.addr});
        if (cur.wr) chk("access_pwdata", bus.o_pwdata, cur.wdata);
        if (nacc_seen == cur.wt + 1) begin
          bus.i_pready[k] = 1'b1; bus.i_pslverr[k] = cur.serr;
          bus.i_prdata[k*32 +: 32] = cur.data;
        end else begin
          bus.i_pready[k] = 1'b0;
        end
      end
    end
  end

  // Response monitor: ready is chosen first, so a valid seen here with ready
  // set completes at the next edge.
  bit          held = 1'b0;
  logic [33:0] held_v;

  always @(negedge clk) begin : mon
    exp_t e; logic [33:0] v;
    bus.i_rsp_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    v = {bus.o_rsp_rdata, bus.o_rsp_err, bus.o_rsp_timeout};
    if (rst) begin
      held = 1'b0;
    end else if (bus.o_rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL rsp_unexpected: rsp_valid with nothing outstanding at cycle %0d", cyc);
      end else begin
        e = exp_q[0];
        if (held) begin
          chk("rsp_stable", v, held_v);
          chk("cmd_ready_busy", bus.o_cmd_ready, 0);
        end else begin
          chk("rsp_latency", cyc, e.due);
          if (!e.dec) chk("access_cycles", nacc_seen, e.nacc);
        end
        if (bus.i_rsp_ready) begin
          chk("rsp_fields", v, {e.rdata, e.err, e.tmo});
          void'(exp_q.pop_front());
          held = 1'b0;
        end else begin
          held = 1'b1; held_v = v;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, idx, wt;
    logic [31:0] a;
    bus.i_cmd_valid = 1'b0; bus.i_cmd_write = 1'b0; bus.i_cmd_addr = '0;
    bus.i_cmd_wdata = '0; bus.i_cmd_strb = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {bus.o_psel, bus.o_penable, bus.o_rsp_valid, bus.o_cmd_ready,
                     bus.o_pwrite, bus.o_rsp_err, bus.o_rsp_timeout}, 0);
    chk("rst_paddr", bus.o_paddr, 0);
    chk("rst_data", {bus.o_pwdata, bus.o_pstrb}, 0);
    chk("rst_rdata", bus.o_rsp_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", bus.o_cmd_ready, 1);

    send(1'b0, 32'h0000_1004, 32'h5555_5555, 4'hF, 0, 1'b0, 32'hCAFE_F00D); drain();
    send(1'b1, 32'h0000_2010, 32'h1122_3344, 4'b0101, 3, 1'b0, 32'h9999_9999); drain();
    send(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 1'b1, 32'hDEAD_BEEF); drain();
    send(1'b0, 32'h0000_1100, 32'h0, 4'h0, 40, 1'b0, 32'h1234_5678); drain();
    send(1'b0, 32'h0000_2200, 32'h0, 4'h0, 15, 1'b0, 32'h0BAD_CAFE); drain();
    send(1'b1, 32'h0000_3000, 32'hAAAA_AAAA, 4'hF, 0, 1'b0, 32'h0); drain();

    bp = 1'b1;
    send(1'b0, 32'h0000_1040, 32'h0, 4'h0, 1, 1'b0, 32'h7654_3210);
    t = 0;
    while (!bus.o_rsp_valid && t < 50) begin @(negedge clk); t++; end
    if (!bus.o_rsp_valid) bound_fail("bp_rsp_valid");
    repeat (10) @(negedge clk);
    bp = 1'b0;
    drain();

    send(1'b0, 32'h0000_1000, 32'h0, 4'h0, 12, 1'b0, 32'h1357_9BDF);
    t = 0;
    while (!bus.o_penable && t < 20) begin @(negedge clk); t++; end
    if (!bus.o_penable) bound_fail("reach_access");
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_xfer", {bus.o_psel, bus.o_penable, bus.o_rsp_valid}, 0);
    exp_q.delete(); plan_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", bus.o_cmd_ready, 1);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      idx = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      wt  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
      a   = $urandom;
      a[13:12] = 2'(idx);
      send(1'($urandom), a, $urandom, 4'($urandom), wt, ($urandom_range(0, 5) == 0), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
